// File: rtl/butterfly_lsu.sv
// butterfly_lsu: MEM-stage load/store unit for the ButterFly RV32IM pipeline.
//
// Takes one request from the EX/MEM register and runs it on the data-memory
// valid/ready interface. It stalls the pipeline until the handshake completes.
// A load that completes returns sign- or zero-extended data through a
// registered MEM/WB output.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   req_valid_i, req_we_i     request present, 1 = store / 0 = load
//   req_addr_i, req_wdata_i   byte address, rs2 store data
//   req_funct3_i, req_rd_i    width/sign code, load destination register
//   stall_o                   hold IF/ID/EX and EX/MEM this cycle
//   dmem_*                    data-memory request (word address, lane strobes)
//   wb_valid_o/rd_o/data_o    one-cycle load writeback pulse
//   err_o, err_addr_o         one-cycle fault pulse (misaligned, illegal, timeout)
//
// Optional build macro: BUTTERFLY_LSU_TIMEOUT_EN. When it is defined, a BUSY
// request is abandoned after TIMEOUT_CYCLES cycles without dmem_ready_i.
module butterfly_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [4:0]  req_rd_i,
  output logic        stall_o,
  output logic        dmem_valid_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // A zero timeout would abandon every request before it could complete.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("butterfly_lsu: TIMEOUT_CYCLES must be non-zero");
  end

  logic [0:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        we_q;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  logic        busy;
  logic        done;
  logic        timeout_hit;
  logic        req_bad;
  logic        f3_illegal;
  logic        misaligned;
  logic [31:0] load_shift;
  logic [31:0] load_data;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  assign busy = (state_q == StBusy);
  assign done = busy && dmem_ready_i;

  // Legality of the incoming request. Byte accesses can never be misaligned.
  always_comb begin
    f3_illegal = 1'b0;
    unique case (req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
      3'b100, 3'b101:         f3_illegal = req_we_i;  // no unsigned stores
      default:                f3_illegal = 1'b1;
    endcase
    misaligned = 1'b0;
    if (req_funct3_i[1:0] == 2'b01) misaligned = req_addr_i[0];
    if (req_funct3_i[1:0] == 2'b10) misaligned = (req_addr_i[1:0] != 2'b00);
    req_bad = f3_illegal || misaligned;
  end

`ifdef BUTTERFLY_LSU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q;

  // The last cycle counted without ready is the one that abandons the request.
  assign timeout_hit = busy && !dmem_ready_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!dmem_ready_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (!busy) begin
      if (req_valid_i && !req_bad) state_d = StBusy;
    end else if (done || timeout_hit) begin
      state_d = StIdle;
    end
  end

  // Upstream is released in the cycle ready arrives, so it advances on the same edge.
  assign stall_o = busy ? (!dmem_ready_i && !timeout_hit) : (req_valid_i && !req_bad);

  // Store lane placement: the datum is replicated across the word and the strobes pick lanes.
  always_comb begin
    unique case (funct3_q[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_strb = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  // Load lane select and extension; funct3[2] selects zero-extension.
  assign load_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    unique case (funct3_q)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b100:  load_data = {24'h0, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b101:  load_data = {16'h0, load_shift[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

  assign dmem_valid_o = busy && !timeout_hit;
  assign dmem_we_o    = busy && we_q;
  assign dmem_addr_o  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_wstrb_o = (busy && we_q) ? st_strb : 4'b0000;
  assign dmem_wdata_o = (busy && we_q) ? st_data : 32'h0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      we_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (!busy && req_valid_i) begin
        if (req_bad) begin
          err_q      <= 1'b1;
          err_addr_q <= req_addr_i;
        end else begin
          addr_q   <= req_addr_i;
          wdata_q  <= req_wdata_i;
          funct3_q <= req_funct3_i;
          rd_q     <= req_rd_i;
          we_q     <= req_we_i;
        end
      end
      // x0 loads still complete the handshake but produce no writeback.
      if (done && !we_q && (rd_q != 5'd0)) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_q;
        wb_data_q  <= load_data;
      end
      if (timeout_hit) begin
        err_q      <= 1'b1;
        err_addr_q <= addr_q;
      end
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule
